// File: rtl/alu_pipe.sv
`timescale 1ns/1ps
// alu_pipe: two-stage pipelined Hack-compatible ALU with a valid/ready handshake,
// carry/overflow flags and an accumulator mode that feeds the last result back as x.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cr,
  output logic             ov
);
  localparam int MSB = WIDTH - 1;

  logic zx, nx, zy, ny, f_op, no_op;
  assign {zx, nx, zy, ny, f_op, no_op} = ctrl;

  logic             s1_valid_reg;
  logic [WIDTH-1:0] xa_reg, ya_reg;
  logic             f_reg, no_reg;

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_reg;
  logic             zr_reg, ng_reg, cr_reg, ov_reg;
  logic [WIDTH-1:0] acc_reg;

  logic             s2_free, s1_adv, accept;
  logic [WIDTH-1:0] xs, xa_next, ya_next;

  assign xs = use_acc ? acc_reg : x;

  // Operand preconditioning: zero then optionally invert, one bit at a time.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pre
      assign xa_next[gi] = (xs[gi] & ~zx) ^ nx;
      assign ya_next[gi] = (y[gi]  & ~zy) ^ ny;
    end
  endgenerate

  // Stage 2 is free if empty or being drained this cycle; an accumulator op
  // waits until stage 1 is empty so acc already holds the previous result.
  assign s2_free  = !out_valid_reg || out_ready;
  assign s1_adv   = s1_valid_reg && s2_free;
  assign in_ready = (!s1_valid_reg || s2_free) && !(use_acc && s1_valid_reg);
  assign accept   = in_valid && in_ready;

  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] r_next, out_next;
  logic             cr_next, ov_next;

  always_comb begin
    sum_full = {1'b0, xa_reg} + {1'b0, ya_reg};
    r_next   = f_reg ? sum_full[MSB:0] : (xa_reg & ya_reg);
    out_next = no_reg ? ~r_next : r_next;
    cr_next  = f_reg & sum_full[WIDTH];
    ov_next  = f_reg & (xa_reg[MSB] == ya_reg[MSB]) & (sum_full[MSB] != xa_reg[MSB]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      xa_reg       <= '0;
      ya_reg       <= '0;
      f_reg        <= 1'b0;
      no_reg       <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid_reg <= 1'b1;
        xa_reg       <= xa_next;
        ya_reg       <= ya_next;
        f_reg        <= f_op;
        no_reg       <= no_op;
      end else if (s1_adv) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      zr_reg        <= 1'b1;
      ng_reg        <= 1'b0;
      cr_reg        <= 1'b0;
      ov_reg        <= 1'b0;
      acc_reg       <= '0;
    end else begin
      if (s1_adv) begin
        out_valid_reg <= 1'b1;
        out_reg       <= out_next;
        zr_reg        <= (out_next == '0);
        ng_reg        <= out_next[MSB];
        cr_reg        <= cr_next;
        ov_reg        <= ov_next;
        acc_reg       <= out_next;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign zr        = zr_reg;
  assign ng        = ng_reg;
  assign cr        = cr_reg;
  assign ov        = ov_reg;

endmodule

// File: tb/tb_alu_pipe.sv
`timescale 1ns/1ps
// Bench for alu_pipe: directed WIDTH=16 scenarios, then randomised traffic at
// WIDTH=8 and WIDTH=32 scored against an integer-arithmetic reference model.
module tb_alu_pipe;
  typedef struct packed {
    logic [31:0] out;
    logic        zr;
    logic        ng;
    logic        cr;
    logic        ov;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid_a  [3];
  logic        use_acc_a   [3];
  logic        out_ready_a [3];
  logic [5:0]  ctrl_a      [3];
  logic [31:0] x_a         [3];
  logic [31:0] y_a         [3];
  wire         in_ready_a  [3];
  wire         out_valid_a [3];
  wire         zr_a [3];
  wire         ng_a [3];
  wire         cr_a [3];
  wire         ov_a [3];
  wire  [31:0] out_a [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: WIDTH=16, instance 1: WIDTH=8, instance 2: WIDTH=32.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int W = (gi == 0) ? 16 : ((gi == 1) ? 8 : 32);
    wire [W-1:0] o;
    alu_pipe #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_a[gi]),
      .in_ready  (in_ready_a[gi]),
      .x         (x_a[gi][W-1:0]),
      .y         (y_a[gi][W-1:0]),
      .ctrl      (ctrl_a[gi]),
      .use_acc   (use_acc_a[gi]),
      .out_valid (out_valid_a[gi]),
      .out_ready (out_ready_a[gi]),
      .out       (o),
      .zr        (zr_a[gi]),
      .ng        (ng_a[gi]),
      .cr        (cr_a[gi]),
      .ov        (ov_a[gi])
    );
    assign out_a[gi] = 32'(o);
  end

  // Reference: operands as plain integers, signed overflow from true signed sums.
  function automatic res_t model(input int w, input logic [31:0] xs, input logic [31:0] yv,
                                 input logic [5:0] c);
    longint m, half, a, b, s, r, sa, sb, ss;
    res_t res;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    res  = '0;
    a = c[5] ? 0 : (longint'(xs) & m);
    if (c[4]) a = m - a;
    b = c[3] ? 0 : (longint'(yv) & m);
    if (c[2]) b = m - b;
    if (c[1]) begin
      s  = a + b;
      r  = s & m;
      res.cr = (s > m);
      sa = (a >= half) ? a - m - 1 : a;
      sb = (b >= half) ? b - m - 1 : b;
      ss = sa + sb;
      res.ov = (ss >= half) || (ss < -half);
    end else begin
      r = a & b;
    end
    if (c[0]) r = m - r;
    res.out = r[31:0];
    res.zr  = (r == 0);
    res.ng  = (r >= half);
    return res;
  endfunction

  function automatic res_t get_obs(input int i);
    return {out_a[i], zr_a[i], ng_a[i], cr_a[i], ov_a[i]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i]  = 1'b0;
      use_acc_a[i]   = 1'b0;
      out_ready_a[i] = 1'b0;
      ctrl_a[i]      = 6'b0;
      x_a[i]         = 32'h0;
      y_a[i]         = 32'h0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid_a[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out_valid[%0d]: got %b expected 0", i, out_valid_a[i]);
      end
      checks++;
      if (get_obs(i) !== {32'h0, 4'b1000}) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %h expected %h", i, get_obs(i), {32'h0, 4'b1000});
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready_a[0]);
    end
  endtask

  task automatic test_basic();
    logic [5:0]  tc [7] = '{6'b000010, 6'b101010, 6'b000010, 6'b000010,
                            6'b010011, 6'b000000, 6'b001100};
    logic [31:0] tx [7] = '{32'h0005, 32'h1234, 32'h7FFF, 32'hFFFF, 32'h0003, 32'hF0F0, 32'h1234};
    logic [31:0] ty [7] = '{32'h0007, 32'hABCD, 32'h0001, 32'h0001, 32'h0009, 32'hFF00, 32'h5555};
    logic [35:0] te [7] = '{{32'h000C, 4'b0000}, {32'h0000, 4'b1000}, {32'h8000, 4'b0101},
                            {32'h0000, 4'b1010}, {32'hFFFA, 4'b0110}, {32'hF000, 4'b0100},
                            {32'h1234, 4'b0000}};
    do_reset();
    out_ready_a[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid_a[0] = 1'b1;
      ctrl_a[0] = tc[k];
      x_a[0] = tx[k];
      y_a[0] = ty[k];
      #1;
      checks++;
      if (in_ready_a[0] !== 1'b1) begin
        errors++;
        $display("FAIL basic_in_ready[%0d]: got %b expected 1", k, in_ready_a[0]);
      end
      step();
      in_valid_a[0] = 1'b0;
      checks++;
      if (out_valid_a[0] !== 1'b0) begin
        errors++;
        $display("FAIL basic_latency_early[%0d]: got out_valid %b expected 0", k, out_valid_a[0]);
      end
      step();
      checks++;
      if (out_valid_a[0] !== 1'b1 || get_obs(0) !== te[k]) begin
        errors++;
        $display("FAIL basic_result[%0d]: got valid %b %h expected valid 1 %h",
                 k, out_valid_a[0], get_obs(0), te[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t q[$];
    res_t e;
    logic [31:0] xv [4];
    logic [31:0] yv [4];
    int k = 0;
    int pops = 0;
    int first = -1;
    int last = -1;
    bit acc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      xv[i] = $urandom & 32'hFFFF;
      yv[i] = $urandom & 32'hFFFF;
    end
    out_ready_a[0] = 1'b0;
    in_valid_a[0]  = 1'b1;
    ctrl_a[0]      = 6'b000010;
    x_a[0] = xv[0];
    y_a[0] = yv[0];
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid_a[0] && q.size() > 0) begin
        checks++;
        if (get_obs(0) !== q[0]) begin
          errors++;
          $display("FAIL b2b_hold[%0d]: got %h expected %h", c, get_obs(0), q[0]);
        end
      end
      acc = in_valid_a[0] && in_ready_a[0];
      if (acc) begin
        q.push_back(model(16, xv[k], yv[k], 6'b000010));
        k++;
      end
      step();
      if (acc) begin
        if (k < 4) begin
          x_a[0] = xv[k];
          y_a[0] = yv[k];
        end else begin
          in_valid_a[0] = 1'b0;
        end
      end
    end
    checks++;
    if (k !== 2) begin
      errors++;
      $display("FAIL b2b_accepts_stalled: got %0d expected 2", k);
    end
    checks++;
    if (in_ready_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_in_ready_full: got %b expected 0", in_ready_a[0]);
    end
    out_ready_a[0] = 1'b1;
    #1;
    checks++;
    if (in_ready_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_in_ready_release: got %b expected 1", in_ready_a[0]);
    end
    for (int c = 0; c < 12 && pops < 4; c++) begin
      #1;
      acc = in_valid_a[0] && in_ready_a[0];
      if (out_valid_a[0]) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_result: got %h expected none", get_obs(0));
        end else begin
          e = q.pop_front();
          if (get_obs(0) !== e) begin
            errors++;
            $display("FAIL b2b_order[%0d]: got %h expected %h", pops, get_obs(0), e);
          end
        end
        if (first < 0) first = c;
        last = c;
        pops++;
      end
      if (acc) begin
        q.push_back(model(16, xv[k], yv[k], 6'b000010));
        k++;
      end
      step();
      if (acc) begin
        if (k < 4) begin
          x_a[0] = xv[k];
          y_a[0] = yv[k];
        end else begin
          in_valid_a[0] = 1'b0;
        end
      end
    end
    checks++;
    if (pops !== 4 || last - first !== 3 || q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_drain: got pops %0d span %0d left %0d expected pops 4 span 3 left 0",
               pops, last - first, q.size());
    end
  endtask

  task automatic test_acc_chain();
    int got = 0;
    int accepts = 0;
    bit acc;
    bit prev_acc = 1'b0;
    do_reset();
    out_ready_a[0] = 1'b1;
    in_valid_a[0]  = 1'b1;
    use_acc_a[0]   = 1'b1;
    ctrl_a[0]      = 6'b011111;
    x_a[0] = $urandom;
    y_a[0] = $urandom;
    for (int c = 0; c < 20 && got < 3; c++) begin
      #1;
      if (prev_acc) begin
        checks++;
        if (in_ready_a[0] !== 1'b0) begin
          errors++;
          $display("FAIL acc_interlock[%0d]: got in_ready %b expected 0", accepts, in_ready_a[0]);
        end
      end
      if (out_valid_a[0]) begin
        checks++;
        if (out_a[0] !== 32'(got + 1)) begin
          errors++;
          $display("FAIL acc_chain[%0d]: got %h expected %h", got, out_a[0], 32'(got + 1));
        end
        got++;
      end
      acc = in_valid_a[0] && in_ready_a[0];
      if (acc) accepts++;
      step();
      prev_acc = acc;
      if (acc && accepts == 3) in_valid_a[0] = 1'b0;
    end
    checks++;
    if (got !== 3) begin
      errors++;
      $display("FAIL acc_chain_count: got %0d expected 3", got);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    out_ready_a[0] = 1'b0;
    in_valid_a[0]  = 1'b1;
    ctrl_a[0]      = 6'b000010;
    x_a[0] = $urandom;
    y_a[0] = $urandom;
    step();
    step();
    in_valid_a[0] = 1'b0;
    checks++;
    if (out_valid_a[0] !== 1'b1 || in_ready_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_full: got valid %b ready %b expected valid 1 ready 0",
               out_valid_a[0], in_ready_a[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid_a[0] !== 1'b0 || get_obs(0) !== {32'h0, 4'b1000} || in_ready_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async: got valid %b %h ready %b expected valid 0 %h ready 1",
               out_valid_a[0], get_obs(0), in_ready_a[0], {32'h0, 4'b1000});
    end
    step();
    rst_n = 1'b1;
    in_valid_a[0]  = 1'b1;
    use_acc_a[0]   = 1'b1;
    out_ready_a[0] = 1'b1;
    ctrl_a[0]      = 6'b011111;
    #1;
    checks++;
    if (in_ready_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready: got %b expected 1", in_ready_a[0]);
    end
    step();
    in_valid_a[0] = 1'b0;
    use_acc_a[0]  = 1'b0;
    step();
    checks++;
    if (out_valid_a[0] !== 1'b1 || out_a[0] !== 32'h1) begin
      errors++;
      $display("FAIL midrst_first_acc: got valid %b out %h expected valid 1 out 1",
               out_valid_a[0], out_a[0]);
    end
  endtask

  task automatic test_random(input int idx, input int w, input int nops);
    res_t q[$];
    res_t e;
    logic [31:0] last_res = 32'h0;
    int sent = 0;
    int recv = 0;
    bit acc;
    do_reset();
    for (int c = 0; c < nops * 20 && recv < nops; c++) begin
      if (!in_valid_a[idx] && sent < nops && $urandom_range(0, 3) != 0) begin
        in_valid_a[idx] = 1'b1;
        x_a[idx]        = $urandom;
        y_a[idx]        = $urandom;
        ctrl_a[idx]     = 6'($urandom_range(0, 63));
        use_acc_a[idx]  = ($urandom_range(0, 3) == 0);
      end
      out_ready_a[idx] = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid_a[idx] && out_ready_a[idx]) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_w%0d_extra: got %h expected none", w, get_obs(idx));
        end else begin
          e = q.pop_front();
          if (get_obs(idx) !== e) begin
            errors++;
            $display("FAIL rand_w%0d[%0d]: got %h expected %h", w, recv, get_obs(idx), e);
          end
        end
        recv++;
      end
      acc = in_valid_a[idx] && in_ready_a[idx];
      if (acc) begin
        e = model(w, use_acc_a[idx] ? last_res : x_a[idx], y_a[idx], ctrl_a[idx]);
        last_res = e.out;
        q.push_back(e);
        sent++;
      end
      step();
      if (acc) in_valid_a[idx] = 1'b0;
    end
    checks++;
    if (recv !== nops || q.size() !== 0) begin
      errors++;
      $display("FAIL rand_w%0d_count: got %0d left %0d expected %0d left 0", w, recv, q.size(), nops);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_back_to_back();
    test_acc_chain();
    test_reset_midstream();
    test_random(1, 8, 300);
    test_random(2, 32, 300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
